// File: rtl/eth_pkg.sv
// Shared definitions for the Ethernet-side serializers: FSM state type,
// the RMII dibit width and a small chunk-count helper.
package eth_pkg;

    // RMII moves two bits per reference clock, hence the default chunk width.
    localparam int RMII_OUTPUT_SIZE = 2;

    // IDLE: no active word held; SHIFT: an active word is being presented.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_e;

    // Number of chunks a word splits into.
    function automatic int chunk_count(input int word_size, input int output_size);
        return word_size / output_size;
    endfunction

endpackage

// File: rtl/chunk_select.sv
// Picks chunk 'index' out of a parallel word, either MSB chunk first
// (REVERSE=0) or LSB chunk first (REVERSE=1).
module chunk_select #(
    parameter int WORD_SIZE   = 8,
    parameter int OUTPUT_SIZE = 2,
    parameter bit REVERSE     = 1'b0,
    parameter int IDX_W       = 2
) (
    input  logic [WORD_SIZE-1:0]   word,
    input  logic [IDX_W-1:0]       index,
    output logic [OUTPUT_SIZE-1:0] chunk
);

    localparam int NUM_CHUNKS = WORD_SIZE / OUTPUT_SIZE;

    // Plain mux over all chunk positions; out-of-range indices give zero.
    always_comb begin
        chunk = '0;
        for (int k = 0; k < NUM_CHUNKS; k++) begin
            if (index == IDX_W'(k)) begin
                if (REVERSE) begin
                    chunk = word[k*OUTPUT_SIZE +: OUTPUT_SIZE];
                end else begin
                    chunk = word[WORD_SIZE-1-k*OUTPUT_SIZE -: OUTPUT_SIZE];
                end
            end
        end
    end

endmodule

// File: rtl/dibit_serializer.sv
// Parallel-to-chunk serializer: one active shift word plus one pending word,
// chunks advanced by a consumer trigger, registered chunk/valid/last outputs.
module dibit_serializer
    import eth_pkg::*;
#(
    parameter int WORD_SIZE   = 8,
    parameter int OUTPUT_SIZE = RMII_OUTPUT_SIZE,
    parameter bit REVERSE     = 1'b0
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic [WORD_SIZE-1:0]   word_in,
    input  logic                   word_valid,
    output logic                   word_ready,
    input  logic                   trigger,
    input  logic [OUTPUT_SIZE-1:0] idle_value,
    output logic [OUTPUT_SIZE-1:0] data_out,
    output logic                   out_valid,
    output logic                   last_out,
    output logic                   underrun
);

    localparam int NUM_CHUNKS = chunk_count(WORD_SIZE, OUTPUT_SIZE);
    localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_CHUNKS - 1);

    // A word must split into a whole number of chunks.
    if ((OUTPUT_SIZE < 1) || (WORD_SIZE < OUTPUT_SIZE) || ((WORD_SIZE % OUTPUT_SIZE) != 0)) begin : g_bad_size
        $error("dibit_serializer: WORD_SIZE must be a positive multiple of OUTPUT_SIZE");
    end

    ser_state_e             state_q, state_d;
    logic [WORD_SIZE-1:0]   active_q, active_d;
    logic [WORD_SIZE-1:0]   pending_q, pending_d;
    logic                   pend_valid_q, pend_valid_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [OUTPUT_SIZE-1:0] data_out_q, data_out_d;
    logic                   out_valid_q, out_valid_d;
    logic                   last_out_q, last_out_d;
    logic                   underrun_q, underrun_d;
    logic                   accept;
    logic [OUTPUT_SIZE-1:0] next_chunk;

    // The only buffer that can refuse a word is the pending one.
    assign word_ready = !pend_valid_q;
    assign accept     = word_valid && word_ready;

    // Next-state logic: word loading, chunk advance and underrun detection.
    always_comb begin
        state_d      = state_q;
        active_d     = active_q;
        pending_d    = pending_q;
        pend_valid_d = pend_valid_q;
        cnt_d        = cnt_q;
        underrun_d   = trigger && !out_valid_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    active_d = word_in;
                    cnt_d    = '0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                if (trigger && (cnt_q == LAST_IDX)) begin
                    cnt_d = '0;
                    if (pend_valid_q) begin
                        active_d     = pending_q;
                        pend_valid_d = 1'b0;
                    end else if (word_valid) begin
                        active_d = word_in;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    if (trigger) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (accept) begin
                        pending_d    = word_in;
                        pend_valid_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    chunk_select #(
        .WORD_SIZE  (WORD_SIZE),
        .OUTPUT_SIZE(OUTPUT_SIZE),
        .REVERSE    (REVERSE),
        .IDX_W      (CNT_W)
    ) u_chunk_select (
        .word (active_d),
        .index(cnt_d),
        .chunk(next_chunk)
    );

    // Outputs are computed from the next state so they can be registered.
    always_comb begin
        out_valid_d = (state_d == SHIFT);
        last_out_d  = (state_d == SHIFT) && (cnt_d == LAST_IDX);
        data_out_d  = (state_d == SHIFT) ? next_chunk : idle_value;
    end

    // State and output registers, cleared asynchronously by rst_in low.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q      <= IDLE;
            active_q     <= '0;
            pending_q    <= '0;
            pend_valid_q <= 1'b0;
            cnt_q        <= '0;
            data_out_q   <= '0;
            out_valid_q  <= 1'b0;
            last_out_q   <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            active_q     <= active_d;
            pending_q    <= pending_d;
            pend_valid_q <= pend_valid_d;
            cnt_q        <= cnt_d;
            data_out_q   <= data_out_d;
            out_valid_q  <= out_valid_d;
            last_out_q   <= last_out_d;
            underrun_q   <= underrun_d;
        end
    end

    assign data_out  = data_out_q;
    assign out_valid = out_valid_q;
    assign last_out  = last_out_q;
    assign underrun  = underrun_q;

endmodule

// File: tb/tb_dibit_serializer.sv
// Scoreboard bench: two serializers (MSB-first and LSB-first) share inputs;
// accepted words are expanded into expected chunks, a monitor compares.
module tb_dibit_serializer;

    localparam int WS = 8;
    localparam int OS = 2;
    localparam int N  = WS / OS;

    typedef struct {
        logic [OS-1:0] d0;
        logic [OS-1:0] d1;
        logic          last;
    } exp_t;

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b0;
    logic [WS-1:0] word_in = '0;
    logic          word_valid = 1'b0;
    logic          trigger = 1'b0;
    logic [OS-1:0] idle_value = '0;

    logic          word_ready0, word_ready1;
    logic [OS-1:0] data_out0, data_out1;
    logic          out_valid0, out_valid1;
    logic          last_out0, last_out1;
    logic          underrun0, underrun1;

    exp_t          exp_q[$];
    int            n_cmp = 0;
    int            n_bad = 0;
    logic          had_valid = 1'b0;
    logic          underrun_exp = 1'b0;
    logic          edge_seen = 1'b0;
    logic [OS-1:0] idle_at_edge = '0;

    always #5 clk_in = ~clk_in;

    dibit_serializer #(.WORD_SIZE(WS), .OUTPUT_SIZE(OS), .REVERSE(1'b0)) dut0 (
        .clk_in(clk_in), .rst_in(rst_in), .word_in(word_in), .word_valid(word_valid),
        .word_ready(word_ready0), .trigger(trigger), .idle_value(idle_value),
        .data_out(data_out0), .out_valid(out_valid0), .last_out(last_out0), .underrun(underrun0)
    );

    dibit_serializer #(.WORD_SIZE(WS), .OUTPUT_SIZE(OS), .REVERSE(1'b1)) dut1 (
        .clk_in(clk_in), .rst_in(rst_in), .word_in(word_in), .word_valid(word_valid),
        .word_ready(word_ready1), .trigger(trigger), .idle_value(idle_value),
        .data_out(data_out1), .out_valid(out_valid1), .last_out(last_out1), .underrun(underrun1)
    );

    task automatic check_output(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Expand a word into its chunk stream from the bit-order rule alone.
    task automatic push_word(input logic [WS-1:0] w);
        exp_t e;
        int   v;
        v = int'(w);
        for (int k = 0; k < N; k++) begin
            e.d0   = OS'((v >> (WS - OS * (k + 1))) % (1 << OS));
            e.d1   = OS'((v >> (OS * k)) % (1 << OS));
            e.last = (k == N - 1);
            exp_q.push_back(e);
        end
    endtask

    function automatic logic ready_model();
        return ((exp_q.size() + N - 1) / N) < 2;
    endfunction

    // One cycle of stimulus; an offered word is scoreboarded only if it will be taken.
    task automatic apply_stimulus(input logic valid, input logic [WS-1:0] w, input logic trig);
        @(negedge clk_in);
        #1;
        word_valid = valid;
        word_in    = w;
        trigger    = trig;
        if (valid && rst_in && ready_model()) push_word(w);
    endtask

    task automatic drain();
        for (int i = 0; i < 3 * N && exp_q.size() > 0; i++) apply_stimulus(1'b0, '0, 1'b1);
        apply_stimulus(1'b0, '0, 1'b0);
        apply_stimulus(1'b0, '0, 1'b0);
    endtask

    // Monitor: compare at negedge, retire chunks at posedge when triggered.
    initial begin
        forever begin
            @(negedge clk_in);
            if (!rst_in) begin
                had_valid = 1'b0;
                check_output("rst_out_valid0", int'(out_valid0), 0);
                check_output("rst_out_valid1", int'(out_valid1), 0);
                check_output("rst_last0", int'(last_out0), 0);
                check_output("rst_underrun0", int'(underrun0), 0);
                check_output("rst_ready0", int'(word_ready0), 1);
                check_output("rst_ready1", int'(word_ready1), 1);
            end else begin
                had_valid = (exp_q.size() > 0);
                check_output("word_ready0", int'(word_ready0), int'(ready_model()));
                check_output("word_ready1", int'(word_ready1), int'(ready_model()));
                check_output("out_valid0", int'(out_valid0), int'(had_valid));
                check_output("out_valid1", int'(out_valid1), int'(had_valid));
                check_output("underrun0", int'(underrun0), int'(underrun_exp));
                check_output("underrun1", int'(underrun1), int'(underrun_exp));
                if (had_valid) begin
                    check_output("data_out0", int'(data_out0), int'(exp_q[0].d0));
                    check_output("data_out1", int'(data_out1), int'(exp_q[0].d1));
                    check_output("last_out0", int'(last_out0), int'(exp_q[0].last));
                    check_output("last_out1", int'(last_out1), int'(exp_q[0].last));
                end else begin
                    check_output("idle_last0", int'(last_out0), 0);
                    check_output("idle_last1", int'(last_out1), 0);
                    if (edge_seen) begin
                        check_output("idle_data0", int'(data_out0), int'(idle_at_edge));
                        check_output("idle_data1", int'(data_out1), int'(idle_at_edge));
                    end
                end
            end
            @(posedge clk_in);
            if (!rst_in) begin
                underrun_exp = 1'b0;
                edge_seen    = 1'b0;
            end else begin
                underrun_exp = trigger && !had_valid;
                if (trigger && had_valid) void'(exp_q.pop_front());
                idle_at_edge = idle_value;
                edge_seen    = 1'b1;
            end
        end
    end

    initial begin
        $display("[TB] start");
        repeat (3) @(negedge clk_in);
        #1 rst_in = 1'b1;
        apply_stimulus(1'b0, '0, 1'b0);

        // Single word, four triggers, then back to idle.
        apply_stimulus(1'b1, 8'h9B, 1'b0);
        for (int i = 0; i < 4; i++) apply_stimulus(1'b0, '0, 1'b1);
        drain();

        // Second word queued while shifting, eight continuous triggers.
        apply_stimulus(1'b1, 8'h9B, 1'b0);
        apply_stimulus(1'b1, 8'h3C, 1'b0);
        for (int i = 0; i < 8; i++) apply_stimulus(1'b0, '0, 1'b1);
        drain();

        // Bypass load on the final-chunk trigger.
        apply_stimulus(1'b1, 8'h9B, 1'b0);
        for (int i = 0; i < 3; i++) apply_stimulus(1'b0, '0, 1'b1);
        apply_stimulus(1'b1, 8'hE4, 1'b1);
        drain();

        // Trigger with nothing to send.
        apply_stimulus(1'b0, '0, 1'b1);
        apply_stimulus(1'b0, '0, 1'b0);
        apply_stimulus(1'b0, '0, 1'b0);

        // Reset mid-word with a pending word.
        apply_stimulus(1'b1, 8'h9B, 1'b0);
        apply_stimulus(1'b1, 8'h3C, 1'b0);
        apply_stimulus(1'b0, '0, 1'b1);
        apply_stimulus(1'b0, '0, 1'b1);
        @(negedge clk_in);
        #1;
        word_valid = 1'b0;
        trigger    = 1'b1;
        rst_in     = 1'b0;
        exp_q.delete();
        #1;
        check_output("async_out_valid0", int'(out_valid0), 0);
        check_output("async_out_valid1", int'(out_valid1), 0);
        check_output("async_ready0", int'(word_ready0), 1);
        repeat (2) @(negedge clk_in);
        #1 rst_in = 1'b1;
        for (int i = 0; i < 3; i++) apply_stimulus(1'b0, '0, 1'b1);
        apply_stimulus(1'b0, '0, 1'b0);
        apply_stimulus(1'b0, '0, 1'b0);

        // Randomized traffic with an occasionally changing idle value.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 19) == 0) idle_value = OS'($urandom_range(0, 3));
            apply_stimulus($urandom_range(0, 99) < 45, WS'($urandom), $urandom_range(0, 99) < 65);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
